// File: rtl/result_frame_tx_pkg.sv
// Shared types and helpers for the WLO host-link result transmitter.
package wlo_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SOF,
    PAYLOAD,
    CSUM
  } tx_state_e;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  // Total bytes on the wire for one result: SOF + payload + checksum.
  function automatic int unsigned frame_bytes(input int unsigned result_wl);
    return result_wl / 8 + 2;
  endfunction

endpackage

// File: rtl/result_frame_tx_if.sv
// Byte-stream valid/ready link from the frame transmitter to the host TX path.
interface result_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/result_frame_tx_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module result_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/result_frame_tx.sv
// Buffers accumulator results and sends each as SOF, payload (MSB first), XOR checksum.
module result_frame_tx
  import wlo_tx_pkg::*;
#(
  parameter int unsigned RESULT_WL  = 64,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [7:0]  SOF_BYTE   = SOF_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [RESULT_WL-1:0] result_in,
  input  logic                 result_valid,
  result_frame_tx_if.master    tx,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int unsigned NB = frame_bytes(RESULT_WL) - 2;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  tx_state_e            r_state, w_state_nxt;
  logic [RESULT_WL-1:0] r_shift, w_shift_nxt;
  logic [7:0]           r_csum, w_csum_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [7:0]           r_tx_data, w_tx_data_nxt;
  logic                 r_tx_valid, w_tx_valid_nxt;
  logic                 r_overflow;

  logic                 w_pop, w_load, w_xfer;
  logic                 w_full, w_empty;
  logic [RESULT_WL-1:0] w_dout;

  result_fifo #(
    .WIDTH (RESULT_WL),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rstn),
    .push  (result_valid),
    .pop   (w_pop),
    .din   (result_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_xfer = r_tx_valid && tx.tx_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_csum_nxt     = r_csum;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_load         = 1'b0;
    case (r_state)
      IDLE: w_load = !w_empty;
      SOF: begin
        if (w_xfer) begin
          w_tx_data_nxt = r_shift[RESULT_WL-1 -: 8];
          w_shift_nxt   = {r_shift[RESULT_WL-9:0], 8'h00};
          w_cnt_nxt     = '0;
          w_state_nxt   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (w_xfer) begin
          w_csum_nxt = r_csum ^ r_tx_data;
          if (r_cnt == CW'(NB - 1)) begin
            w_tx_data_nxt = r_csum ^ r_tx_data;
            w_state_nxt   = CSUM;
          end else begin
            w_tx_data_nxt = r_shift[RESULT_WL-1 -: 8];
            w_shift_nxt   = {r_shift[RESULT_WL-9:0], 8'h00};
            w_cnt_nxt     = r_cnt + 1'b1;
          end
        end
      end
      CSUM: begin
        if (w_xfer) begin
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Shared frame start: reached from IDLE, or straight from a checksum transfer with no bubble.
    if (w_load) begin
      w_shift_nxt    = w_dout;
      w_csum_nxt     = '0;
      w_cnt_nxt      = '0;
      w_tx_data_nxt  = SOF_BYTE;
      w_tx_valid_nxt = 1'b1;
      w_state_nxt    = SOF;
    end
    w_pop = w_load;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_csum     <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_csum     <= w_csum_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  // A same-edge pop frees a slot, so only a push that truly finds no room counts as a drop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (result_valid && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign busy        = (r_state != IDLE) || !w_empty;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_result_frame_tx.sv
// Scoreboarded random and directed bench for result_frame_tx.
module tb_result_frame_tx;

  localparam int FB = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] result_in;
  logic        result_valid;
  logic        busy, overflow, clr_overflow;

  result_frame_tx_if tx_if ();

  result_frame_tx #(
    .RESULT_WL  (64),
    .FIFO_DEPTH (2),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .result_in    (result_in),
    .result_valid (result_valid),
    .tx           (tx_if.master),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  int n_xfer = 0, n_push = 0;
  int cyc = 0, first_valid = 0, last_xfer = 0, valid_cyc = 0;
  bit arm_first = 0;
  int rdy_mode = 1;  // 0 low, 1 high, 2 alternate, 3 random

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference frame: SOF, bytes MSB first, XOR of the payload bytes.
  task automatic add_frame(input logic [63:0] v);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      b = 8'((v >> (56 - 8 * i)) & 64'hFF);
      cs = cs ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(cs);
  endtask

  // Monitor: compares every presented byte against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (rstn && tx_if.tx_valid) begin
      valid_cyc++;
      if (arm_first) begin
        first_valid = cyc;
        arm_first = 0;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 1, 0);
      end else if (tx_if.tx_ready) begin
        chk("byte", tx_if.tx_data, exp_q.pop_front());
        n_xfer++;
        last_xfer = cyc;
      end else begin
        chk("stall_hold", tx_if.tx_data, exp_q[0]);
      end
    end
  end

  // Ready driver; alternate mode restarts with ready=1 whenever no byte is pending.
  initial begin
    bit ph;
    ph = 0;
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: tx_if.tx_ready = 1'b0;
        1: tx_if.tx_ready = 1'b1;
        2: begin
          if (!tx_if.tx_valid) begin
            ph = 0;
            tx_if.tx_ready = 1'b1;
          end else begin
            tx_if.tx_ready = (ph == 0);
            ph = ~ph;
          end
        end
        default: tx_if.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [63:0] v, input bit accept);
    result_in = v;
    result_valid = 1'b1;
    if (accept) begin
      add_frame(v);
      n_push++;
    end
    @(posedge clk);
    #1;
    result_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && !tx_if.tx_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_xfer(input int target);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_xfer == target) break;
    end
    chk("xfer_wait", n_xfer, target);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base;
    rstn = 1'b0;
    result_in = '0;
    result_valid = 1'b0;
    clr_overflow = 1'b0;
    #2;
    chk("rst_tx_valid", tx_if.tx_valid, 0);
    chk("rst_tx_data", tx_if.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    idle_cycles(2);

    // Single frame, ready always high: latency, contiguity, busy.
    rdy_mode = 1;
    idle_cycles(1);
    arm_first = 1;
    valid_cyc = 0;
    send(64'h0123_4567_89AB_CDEF, 1);
    chk("lat_not_yet", tx_if.tx_valid, 0);
    chk("busy_fifo", busy, 1);
    idle_cycles(1);
    chk("lat_valid", tx_if.tx_valid, 1);
    chk("lat_sof", tx_if.tx_data, 8'hA5);
    wait_drain();
    chk("t1_valid_cycles", valid_cyc, 10);
    chk("t1_span", last_xfer - first_valid + 1, 10);
    chk("t1_busy_end", busy, 0);

    // Same frame, ready alternating.
    rdy_mode = 2;
    idle_cycles(2);
    arm_first = 1;
    send(64'h0123_4567_89AB_CDEF, 1);
    wait_drain();
    chk("t2_span", last_xfer - first_valid + 1, 19);

    // Two results two cycles apart: back-to-back frames.
    rdy_mode = 1;
    idle_cycles(2);
    arm_first = 1;
    send(64'h1, 1);
    idle_cycles(1);
    send(64'h2, 1);
    wait_drain();
    chk("t3_span", last_xfer - first_valid + 1, 20);

    // Overflow: shifter plus two FIFO slots, then a drop.
    rdy_mode = 0;
    idle_cycles(2);
    send(64'hAAAA_0000_0000_0001, 1);
    send(64'hAAAA_0000_0000_0002, 1);
    send(64'hAAAA_0000_0000_0003, 1);
    chk("t4_no_ovf", overflow, 0);
    send(64'hDEAD_BEEF_DEAD_BEEF, 0);
    chk("t4_ovf_set", overflow, 1);
    chk("t4_busy", busy, 1);
    clr_overflow = 1'b1;
    idle_cycles(1);
    clr_overflow = 1'b0;
    chk("t4_ovf_clr", overflow, 0);
    clr_overflow = 1'b1;
    send(64'hBAD0_BAD0_BAD0_BAD0, 0);
    clr_overflow = 1'b0;
    chk("t4_drop_beats_clr", overflow, 1);
    clr_overflow = 1'b1;
    idle_cycles(1);
    clr_overflow = 1'b0;
    chk("t4_ovf_clr2", overflow, 0);
    rdy_mode = 1;
    wait_drain();

    // Push while full, coincident with the checksum transfer that pops.
    rdy_mode = 0;
    idle_cycles(2);
    send(64'h1111_2222_3333_4444, 1);
    send(64'h5555_6666_7777_8888, 1);
    send(64'h9999_AAAA_BBBB_CCCC, 1);
    base = n_xfer;
    rdy_mode = 1;
    wait_xfer(base + FB);
    result_in = 64'hCAFE_F00D_1234_5678;
    result_valid = 1'b1;
    add_frame(64'hCAFE_F00D_1234_5678);
    n_push++;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    chk("t6_no_ovf", overflow, 0);
    wait_drain();
    chk("t6_no_ovf_end", overflow, 0);

    // Random results and ready, throttled so no result can be dropped.
    rdy_mode = 3;
    for (int k = 0; k < 40; k++) begin
      for (int w = 0; w < 300; w++) begin
        if (n_push - n_xfer / FB < 2) break;
        idle_cycles(1);
      end
      idle_cycles($urandom_range(0, 4));
      send({$urandom, $urandom}, 1);
    end
    wait_drain();
    chk("rand_no_ovf", overflow, 0);

    // Asynchronous reset after four bytes of a frame.
    rdy_mode = 1;
    idle_cycles(2);
    send(64'h7654_3210_FEDC_BA98, 1);
    base = n_xfer;
    wait_xfer(base + 4);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_valid", tx_if.tx_valid, 0);
    chk("rst_mid_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    idle_cycles(1);
    chk("rst_after_idle", tx_if.tx_valid, 0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1);
    wait_drain();
    chk("rst_after_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
